// File: rtl/pe_pkg.sv
// Shared constants and elaboration helpers for the parallel dot-product PE.
// Pure package: no logic, no latency, no flow control.
package pe_pkg;

  localparam int PE_CTL_FIRST = 0;
  localparam int PE_CTL_LAST  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Adder-tree output width: full product width plus one growth bit per tree level.
  function automatic int sum_w(input int dw, input int lanes);
    return 2 * dw + clog2(lanes);
  endfunction

endpackage

// File: rtl/param_parallel_pe_if.sv
// Beat input / result output bundle of the parallel PE.
// Valid/ready on both sides; the PE is the slave of both directions.
interface param_parallel_pe_if #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int ACC_W = 32
) ();

  logic [LANES*DW-1:0] neuron;
  logic [LANES*DW-1:0] weight;
  logic [1:0]          ctl;
  logic                vld_i;
  logic                rdy_o;
  logic [ACC_W-1:0]    result;
  logic                vld_o;
  logic                rdy_i;
  logic                sat_o;

  modport slave (
    input  neuron, weight, ctl, vld_i, rdy_i,
    output rdy_o, result, vld_o, sat_o
  );

  modport master (
    output neuron, weight, ctl, vld_i, rdy_i,
    input  rdy_o, result, vld_o, sat_o
  );

endinterface

// File: rtl/pe_adder_tree.sv
// Registered reduction of N signed IW-bit inputs into one OW-bit sum; 1 clock latency.
// Holds its output register while en is low (pipeline stall).
module pe_adder_tree
  import pe_pkg::*;
#(
  parameter int N  = 32,
  parameter int IW = 32,
  parameter int OW = IW + clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N*IW-1:0]      din,
  output logic signed [OW-1:0] sum
);

  localparam int L = clog2(N);

  // Level 0 holds the sign-extended leaves; each further level halves the node count.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    logic signed [OW-1:0] v [N>>l];
    for (genvar j = 0; j < (N >> l); j++) begin : g_n
      if (l == 0) begin : g_leaf
        assign v[j] = OW'($signed(din[j*IW +: IW]));
      end else begin : g_add
        assign v[j] = g_lvl[l-1].v[2*j] + g_lvl[l-1].v[2*j+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (en) begin
      sum <= g_lvl[L].v[0];
    end
  end

endmodule

// File: rtl/param_parallel_pe.sv
// LANES-wide signed dot-product PE with accumulation; PARALLEL_PE_SAT_EN selects saturating arithmetic.
// Result valid on the 3rd edge counting the accepting one; vld_o && !rdy_i freezes every stage.
module param_parallel_pe
  import pe_pkg::*;
#(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int ACC_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  param_parallel_pe_if.slave  bus
);

  localparam int PW    = 2 * DW;
  localparam int SUM_W = sum_w(DW, LANES);

  logic                    stall;
  logic [LANES*PW-1:0]     prod_c;
  logic [LANES*PW-1:0]     s1_prod;
  logic [1:0]              s1_ctl;
  logic                    s1_v;
  logic signed [SUM_W-1:0] s2_sum;
  logic [1:0]              s2_ctl;
  logic                    s2_v;
  logic signed [ACC_W-1:0] sum_n;
  logic                    narrow_ovf;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] result_q;
  logic                    vld_q;
  logic                    first;
  logic                    last;

  assign stall      = vld_q && !bus.rdy_i;
  assign bus.rdy_o  = !stall;
  assign bus.vld_o  = vld_q;
  assign bus.result = result_q;

  always_comb begin
    prod_c = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_c[i*PW +: PW] = PW'($signed(bus.neuron[i*DW +: DW])) *
                           PW'($signed(bus.weight[i*DW +: DW]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_prod <= '0;
      s1_ctl  <= '0;
      s1_v    <= 1'b0;
      s2_ctl  <= '0;
      s2_v    <= 1'b0;
    end else if (!stall) begin
      s1_prod <= prod_c;
      s1_ctl  <= bus.ctl;
      s1_v    <= bus.vld_i;
      s2_ctl  <= s1_ctl;
      s2_v    <= s1_v;
    end
  end

  pe_adder_tree #(
    .N  (LANES),
    .IW (PW),
    .OW (SUM_W)
  ) u_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall),
    .din   (s1_prod),
    .sum   (s2_sum)
  );

  // Narrow the tree sum to accumulator width; overflow means the dropped bits are not all sign.
  if (SUM_W > ACC_W) begin : g_trunc
    assign sum_n      = s2_sum[ACC_W-1:0];
    assign narrow_ovf = !((&s2_sum[SUM_W-1:ACC_W-1]) || !(|s2_sum[SUM_W-1:ACC_W-1]));
  end else begin : g_sext
    assign sum_n      = ACC_W'(s2_sum);
    assign narrow_ovf = 1'b0;
  end

  assign first = s2_ctl[PE_CTL_FIRST];
  assign last  = s2_ctl[PE_CTL_LAST];

`ifdef PARALLEL_PE_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   wide;
  logic                    sat_flag;
  logic                    sat_next;
  logic                    sat_q;

  always_comb begin
    sum_c = sum_n;
    if (narrow_ovf) sum_c = s2_sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
    base     = first ? '0 : acc;
    wide     = {base[ACC_W-1], base} + {sum_c[ACC_W-1], sum_c};
    acc_next = wide[ACC_W-1:0];
    sat_next = (first ? 1'b0 : sat_flag) | narrow_ovf;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      acc_next = wide[ACC_W] ? ACC_MIN : ACC_MAX;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      sat_q    <= 1'b0;
    end else if (!stall && s2_v) begin
      sat_flag <= sat_next;
      if (last) sat_q <= sat_next;
    end
  end

  assign bus.sat_o = sat_q;
`else
  logic unused_narrow;

  assign acc_next      = first ? sum_n : acc + sum_n;
  assign unused_narrow = narrow_ovf;
  assign bus.sat_o     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      result_q <= '0;
      vld_q    <= 1'b0;
    end else if (!stall) begin
      if (s2_v) acc <= acc_next;
      if (s2_v && last) result_q <= acc_next;
      vld_q <= s2_v && last;
    end
  end

endmodule

// File: tb/tb_param_parallel_pe.sv
// Randomised and directed bench for param_parallel_pe against a dot-product scoreboard.
module tb_param_parallel_pe;

  localparam int  LANES = 32;
  localparam int  DW    = 16;
  localparam int  ACC_W = 32;
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;
`ifdef PARALLEL_PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_parallel_pe_if #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) bus ();

  param_parallel_pe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: running dot-product accumulator and queue of results not yet handed off.
  typedef struct { longint res; bit sat; } exp_t;
  exp_t   q[$];
  longint macc  = 0;
  bit     mflag = 1'b0;

  function automatic longint wrap32(input longint x);
    longint w;
    w = x & 64'hFFFF_FFFF;
    if (w >= 64'sh8000_0000) w = w - 64'sh1_0000_0000;
    return w;
  endfunction

  task automatic model_beat(input logic [LANES*DW-1:0] n, input logic [LANES*DW-1:0] w, input logic [1:0] c);
    longint s;
    longint base;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      s += longint'($signed(n[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
    end
    base = c[0] ? 0 : macc;
    if (SAT) begin
      if (c[0]) mflag = 1'b0;
      if (s > AMAX) begin s = AMAX; mflag = 1'b1; end
      else if (s < AMIN) begin s = AMIN; mflag = 1'b1; end
      s = base + s;
      if (s > AMAX) begin s = AMAX; mflag = 1'b1; end
      else if (s < AMIN) begin s = AMIN; mflag = 1'b1; end
      macc = s;
    end else begin
      macc = wrap32(base + wrap32(s));
    end
    if (c[1]) q.push_back('{macc, mflag});
  endtask

  logic                    s_vld, s_rdy_o, s_rdy_i, s_vldi, s_sat;
  logic signed [ACC_W-1:0] s_res;
  logic [LANES*DW-1:0]     s_n, s_w;
  logic [1:0]              s_c;

  // One clock: sample at the falling edge, score outputs, then account for the rising edge.
  task automatic tick();
    @(negedge clk);
    s_vld = bus.vld_o; s_rdy_o = bus.rdy_o; s_rdy_i = bus.rdy_i; s_vldi = bus.vld_i;
    s_sat = bus.sat_o; s_res = bus.result; s_n = bus.neuron; s_w = bus.weight; s_c = bus.ctl;
    check("rdy_o", s_rdy_o, !(s_vld && !s_rdy_i));
    if (s_vld) begin
      if (q.size() == 0) begin
        check("spurious_vld", 1, 0);
      end else begin
        check("result", s_res, q[0].res);
        check("sat", s_sat, q[0].sat);
      end
    end
    @(posedge clk);
    #1;
    if (s_vld && s_rdy_i && q.size() > 0) void'(q.pop_front());
    if (s_vldi && s_rdy_o) model_beat(s_n, s_w, s_c);
  endtask

  task automatic drive(input int nv, input int wv, input logic [1:0] c);
    for (int i = 0; i < LANES; i++) begin
      bus.neuron[i*DW +: DW] = DW'(nv);
      bus.weight[i*DW +: DW] = DW'(wv);
    end
    bus.ctl   = c;
    bus.vld_i = 1'b1;
  endtask

  task automatic idle();
    bus.vld_i = 1'b0;
    bus.ctl   = 2'b00;
  endtask

  task automatic expect_result(input string tag, input longint exp, input bit esat, input int budget);
    int k;
    k = 0;
    while (!bus.vld_o && k < budget) begin
      tick();
      k++;
    end
    if (!bus.vld_o) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check(tag, $signed(bus.result), exp);
      check({tag, "_sat"}, bus.sat_o, esat);
    end
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    idle();
    macc  = 0;
    mflag = 1'b0;
    q.delete();
    @(negedge clk);
    check({tag, "_vld_o"}, bus.vld_o, 0);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_rdy_o"}, bus.rdy_o, 1);
    check({tag, "_sat_o"}, bus.sat_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int k;
    bus.neuron = '0; bus.weight = '0; bus.ctl = 2'b00; bus.vld_i = 1'b0; bus.rdy_i = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    apply_reset("reset");

    // Single beat: the accepting edge counts as the first of three.
    drive(1, 2, 2'b11);
    tick();
    check("single_e1_vld", bus.vld_o, 0);
    idle();
    tick();
    check("single_e2_vld", bus.vld_o, 0);
    tick();
    check("single_e3_vld", bus.vld_o, 1);
    check("single_result", $signed(bus.result), 64);
    tick();
    check("single_e4_vld", bus.vld_o, 0);

    drive(3, -1, 2'b01); tick();
    drive(3, -1, 2'b00); tick();
    drive(3, -1, 2'b10); tick();
    idle();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.vld_o) begin
        pulses++;
        check("seq3_result", $signed(bus.result), -288);
      end
    end
    check("seq3_pulses", pulses, 1);

    bus.rdy_i = 1'b0;
    drive(1, 2, 2'b11); tick();
    drive(2, 3, 2'b01); tick();
    drive(2, 3, 2'b10); tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_rdy_o", bus.rdy_o, 0);
      check("bp_hold", $signed(bus.result), 64);
    end
    bus.rdy_i = 1'b1;
    tick();
    expect_result("bp_second", 384, 0, 4);
    tick();

    drive(32767, 32767, 2'b01); tick();
    drive(32767, 32767, 2'b00); tick();
    drive(32767, 32767, 2'b10); tick();
    idle();
    expect_result("ovf", SAT ? AMAX : -64'sd6291360, SAT, 5);
    tick();
    drive(1, 1, 2'b11); tick();
    idle();
    expect_result("sat_clear", 32, 0, 5);
    tick();

    drive(1, 1, 2'b01); tick();
    drive(1, 1, 2'b00); tick();
    drive(1, 1, 2'b00);
    apply_reset("midrst");
    drive(1, 1, 2'b11); tick();
    idle();
    expect_result("post_rst", 32, 0, 5);
    tick();

    for (int i = 0; i < 400; i++) begin
      bus.rdy_i = ($urandom_range(0, 3) != 0);
      bus.vld_i = ($urandom_range(0, 3) != 0);
      bus.ctl   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      for (int j = 0; j < LANES; j++) begin
        bus.neuron[j*DW +: DW] = (i % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 15) - 8);
        bus.weight[j*DW +: DW] = (i % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 15) - 8);
      end
      tick();
    end
    idle();
    bus.rdy_i = 1'b1;
    k = 0;
    while (q.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    check("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_parallel_pe.md
Name: param_parallel_pe

Overview:
Next-generation dot-product processing element for the matrix_pe path.
- Computes LANES signed DW-bit neuron×weight products per beat, reduces them with a pipelined adder tree and accumulates across a first/last-delimited sequence of beats.
- Adds three things over the fixed-width combinational PE: a registered pipeline, a valid/ready handshake on both sides with full backpressure, and signed, width-parametrised arithmetic.
- Instantiated per output channel by the matrix PE array.

Parameters:
LANES, 32, number of parallel multiply lanes (power of 2, ≥2)
DW, 16, signed element width of neuron/weight lanes
ACC_W, 32, accumulator and result width (≥ 2*DW)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
neuron  input  LANES*DW  packed signed neurons, lane i at [i*DW +: DW]
weight  input  LANES*DW  packed signed weights, same packing
ctl  input  2  ctl[0]=first beat (restart accumulation), ctl[1]=last beat (emit result)
vld_i  input  1  input beat valid
rdy_o  output  1  PE can accept a beat
result  output  ACC_W  signed dot-product result, stable while vld_o=1
vld_o  output  1  result valid
rdy_i  input  1  downstream accepts result
sat_o  output  1  result saturated (PE_SAT_EN only; otherwise tied 0)

Behaviour:
- Reset: all pipeline registers, accumulator, result, vld_o and sat_o go to 0. rdy_o = 1 out of reset. A mid-sequence reset discards the partial sum and all in-flight beats.
- Beat acceptance: a beat is accepted when vld_i && rdy_o. rdy_o = !stall, where stall = vld_o && !rdy_i.
- Stall: while stall=1, every pipeline stage, the accumulator, result and the S1/S2 valid bits hold their values.
- S1 (registered): LANES products, each 2*DW signed. ctl and the valid bit ride alongside.
- S2 (registered): adder-tree sum, width 2*DW+log2(LANES), signed.
- S3 (accumulator update):
  - sum = sign-extended or truncated S2 value at ACC_W.
  - acc_next = ctl_first ? sum : acc + sum.
  - Overflow wraps modulo 2^ACC_W.
- Result capture: when an S3 beat carries ctl_last, result <= acc_next and vld_o <= 1 on that edge.
- Latency: 3 clocks from the accepting edge of the last beat to vld_o high, assuming no stalls.
- Throughput: 1 beat/clock.
- vld_o falls on a cycle with rdy_i=1 unless a new last beat completes on the same edge. In that case vld_o stays 1 and result takes the new value, so back-to-back results are possible.
- Beat with first and last both set: single-beat dot product, result = sum.
- Last without a preceding first: accumulates onto the existing acc. This is legal and used for bias carry-over.
- Bubbles (vld_i=0): the valid bit propagates as 0 and acc is unchanged.

Optional Feature:
- Macro: PARALLEL_PE_SAT_EN.
- Defined:
  - S3 uses saturating signed add; acc_next is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - The S2 sum is also clamped when it is narrowed to ACC_W.
  - A sticky saturation flag is set by any clamp in the sequence and cleared on a first beat.
  - The flag is copied to sat_o alongside result.
- Undefined: wrap-around arithmetic; sat_o = 0.

Decomposition:
- Package pe_pkg holds:
  - ctl bit index constants PE_CTL_FIRST=0 and PE_CTL_LAST=1;
  - a clog2 helper;
  - the localparam SUM_W = 2*DW + clog2(LANES) formula.
- One sub-module, pe_adder_tree: parametrised registered reduction of LANES signed inputs with a stall/enable input.
- Multipliers and the accumulator stay in the top module.

Test Plan:
All scenarios use default parameters.
- Single beat: all lanes neuron=1, weight=2, ctl=2'b11, rdy_i=1 -> result=64 and vld_o=1 exactly 3 clocks after the accepting edge, for one cycle only.
- Three-beat sequence: neuron=3, weight=-1, ctl=01,00,10 on consecutive clocks -> result=-288 (0xFFFFFEE0), single vld_o pulse.
- Backpressure: hold rdy_i=0 while result=64 is valid and stream a second 2-beat sequence -> rdy_o=0, result stays 64 and all stages hold; on rdy_i=1 the first result retires, and the second result follows with the correct value.
- Overflow: neuron=weight=32767 in all lanes, 3 beats first..last:
  - without the macro -> result = low 32 bits of 3*32*1073676289, sat_o=0;
  - with PARALLEL_PE_SAT_EN -> result=0x7FFFFFFF, sat_o=1, and the next first-beat sequence clears sat_o.
- Reset mid-operation: assert rst_n=0 after 2 beats of a 4-beat sequence -> vld_o=0, result=0, rdy_o=1 next cycle; a fresh single beat (1×1 in all lanes) yields 32.
